csa_resolver: RTL and testbench

- Sequential carry-propagate back end for carry-save arithmetic.
- Accepts one redundant (sum, carry) vector pair, as produced by a row of full adders (carry bit i weighted 2^(i+1)).
- Resolves the pair to a plain binary value CHUNK bits per cycle, using a single narrow adder and a carry flop.
- Sits after the CSA compression tree and drives consumers that need binary results; uses valid/ready on both sides.

---
 rtl/csa_resolver.sv | 132 +++++++++++++
 tb/tb_csa_resolver.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : csa_resolver
//  Purpose  : Sequential carry-propagate back end for a carry-save pair.
//             Resolves s_in + 2*c_in to plain binary CHUNK bits per cycle
//             using one CHUNK-bit adder and a carry flop.
//  Ports    : clk, rst (async, active-high)
//             in_valid / in_ready    - operand handshake (s_in, c_in)
//             out_valid / out_ready  - result handshake (sum_out)
//             busy                   - high while chunks are being resolved
//  Options  : CSA_RESOLVER_EARLY_EXIT_EN - finish as soon as the remaining
//             upper chunks of both operands are zero and no carry is pending.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_resolver #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] sum_out,
  output logic             busy
);

  localparam int NCHUNK = (WIDTH + 2 + CHUNK - 1) / CHUNK;
  localparam int P      = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [CW-1:0] c_last_idx = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [P-1:0]    r_a;
  logic [P-1:0]    r_b;
  logic [P-1:0]    r_r;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [CHUNK:0]  w_sum;
  logic            w_accept;
  logic            w_last_chunk;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY);
  assign sum_out   = r_r[WIDTH+1:0];
  assign w_accept  = in_valid && (r_state == S_IDLE);

  // Operands are shifted right as they are consumed, so the chunk being
  // resolved is always in the low CHUNK bits.
  assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, r_carry};

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
  // Remaining operand bits all zero and no carry out: the upper result
  // chunks are already correct from the clear at accept.
  logic w_early;
  assign w_early      = !w_sum[CHUNK] && !(|(r_a >> CHUNK)) && !(|(r_b >> CHUNK));
  assign w_last_chunk = (r_cnt == c_last_idx) || w_early;
`else
  assign w_last_chunk = (r_cnt == c_last_idx);
`endif

  // Result bits above WIDTH+1 only exist because of chunk padding; the
  // value never reaches them.
  generate
    if (P > WIDTH + 2) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^r_r[P-1:WIDTH+2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)     w_state_next = S_BUSY;
      S_BUSY:  if (w_last_chunk) w_state_next = S_DONE;
      S_DONE:  if (out_ready)    w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= {{(P-WIDTH){1'b0}}, s_in};
      r_b     <= {{(P-WIDTH-1){1'b0}}, c_in, 1'b0};
      r_r     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_BUSY) begin
      r_r[r_cnt*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_sum[CHUNK];
      r_cnt   <= r_cnt + CW'(1);
    end
  end

`ifndef SYNTHESIS
  // Padded width always covers the full sum, so no carry can leave the top.
  a_no_final_carry: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_BUSY && w_state_next == S_DONE) |-> !w_sum[CHUNK]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_resolver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_csa_resolver
//  Purpose  : Self-checking bench for csa_resolver. Directed cases on an
//             8-bit/4-bit-chunk and a 32-bit/8-bit-chunk instance, plus four
//             randomized 32-bit lanes (CHUNK = 1, 5, 8, 34) compared every
//             cycle against a latency/value model built from plain arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_resolver;

  localparam int NPAIR = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ch_of(int i);
    case (i)
      0:       return 1;
      1:       return 5;
      2:       return 8;
      default: return 34;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- directed instance: WIDTH=8, CHUNK=4 ----------------
  logic       rst8, iv8, ir8, ov8, or8, bz8;
  logic [7:0] s8, c8;
  logic [9:0] sum8;

  csa_resolver #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .s_in(s8), .c_in(c8),
    .out_valid(ov8), .out_ready(or8), .sum_out(sum8), .busy(bz8));

  // ---------------- directed instance: WIDTH=32, CHUNK=8 ----------------
  logic        rst32, iv32, ir32, ov32, or32, bz32;
  logic [31:0] s32, c32;
  logic [33:0] sum32;

  csa_resolver #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32), .s_in(s32), .c_in(c32),
    .out_valid(ov32), .out_ready(or32), .sum_out(sum32), .busy(bz32));

  task automatic acc8(input logic [7:0] s, input logic [7:0] c, output int lat);
    s8 = s; c8 = c; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic acc32(input logic [31:0] s, input logic [31:0] c, output int lat);
    s32 = s; c32 = c; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic rel8(input string name);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check(name, ir8, 1);
  endtask

  // ---------------- randomized lanes ----------------
  bit lane_done [4];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int C   = ch_of(g);
    localparam int NCH = (34 + C - 1) / C;

    logic        rst_l, iv, ir, ov, ordy, bz;
    logic [31:0] s, c;
    logic [33:0] so;
    int          m_st  = 0;   // 0 idle, 1 resolving, 2 result held
    int          m_cnt = 0;
    int          n_acc = 0;
    logic [33:0] m_exp = '0;
    logic [33:0] q[$];

    csa_resolver #(.WIDTH(32), .CHUNK(C)) u_dut (
      .clk(clk), .rst(rst_l), .in_valid(iv), .in_ready(ir), .s_in(s), .c_in(c),
      .out_valid(ov), .out_ready(ordy), .sum_out(so), .busy(bz));

    // Cycles from accept to result: NCHUNK, or with early exit the fewest
    // chunks n such that A, B and A+B all fit in n*CHUNK bits.
    function automatic int lat_of(logic [31:0] sv, logic [31:0] cv);
      logic [63:0] a;
      logic [63:0] b;
      int n;
      a = 64'(sv);
      b = 64'(cv) << 1;
      n = NCH;
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
      for (int k = NCH; k >= 1; k--)
        if ((a >> (k*C)) == 0 && (b >> (k*C)) == 0 && ((a + b) >> (k*C)) == 0) n = k;
`else
      if (a == 64'd0 && b == 64'd0) n = NCH;
`endif
      return n;
    endfunction

    always @(posedge clk) begin
      if (!rst_l) begin
        case (m_st)
          0: if (iv) begin
               m_st  <= 1;
               m_cnt <= lat_of(s, c);
               m_exp <= 34'(s) + (34'(c) << 1);
               q.push_back(34'(s) + (34'(c) << 1));
               n_acc <= n_acc + 1;
             end
          1: if (m_cnt == 1) m_st <= 2; else m_cnt <= m_cnt - 1;
          default: if (ordy) m_st <= 0;
        endcase
      end
    end

    always @(negedge clk) begin
      if (!rst_l) begin
        check($sformatf("lane%0d_in_ready", g), ir, (m_st == 0));
        check($sformatf("lane%0d_busy", g), bz, (m_st == 1));
        check($sformatf("lane%0d_out_valid", g), ov, (m_st == 2));
        if (m_st == 2) begin
          check($sformatf("lane%0d_sum_out", g), so, m_exp);
          if (ordy) begin
            if (q.size() == 0) check($sformatf("lane%0d_queue_empty", g), 1, 0);
            else check($sformatf("lane%0d_order", g), so, q.pop_front());
          end
        end
      end
    end

    initial begin
      rst_l = 1'b1; iv = 1'b0; ordy = 1'b0; s = '0; c = '0;
      lane_done[g] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_l = 1'b0;
      for (int cyc = 0; cyc < 60000 && !(n_acc >= NPAIR && m_st == 0); cyc++) begin
        @(posedge clk); #1;
        iv   = (n_acc < NPAIR) && ($urandom_range(0, 3) != 0);
        s    = pick();
        c    = pick();
        ordy = ($urandom_range(0, 2) != 0);
      end
      iv = 1'b0;
      check($sformatf("lane%0d_drained", g), (n_acc >= NPAIR && m_st == 0), 1);
      lane_done[g] = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  lat;
    bit  seen;
    bit  all_done;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; s8 = '0; c8 = '0;
    rst32 = 1'b1; iv32 = 1'b0; or32 = 1'b0; s32 = '0; c32 = '0;
    #1;
    check("reset_in_ready", ir8, 1);
    check("reset_out_valid", ov8, 0);
    check("reset_busy", bz8, 0);
    check("reset_sum_out", sum8, 0);
    @(posedge clk); #1;
    rst8 = 1'b0; rst32 = 1'b0;

    // full-width operands: carries ripple through every chunk
    acc8(8'hFF, 8'hFF, lat);
    check("ff_ff_latency", lat, 3);
    check("ff_ff_sum", sum8, 10'h2FD);
    rel8("ff_ff_in_ready_after");

    acc8(8'h01, 8'h01, lat);
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
    check("one_one_latency", lat, 1);
`else
    check("one_one_latency", lat, 3);
`endif
    check("one_one_sum", sum8, 10'h003);
    rel8("one_one_in_ready_after");

    // backpressure: result must hold; stray in_valid must be ignored
    acc8(8'h3C, 8'hA5, lat);
    check("bp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin iv8 = 1'b1; s8 = 8'h10; c8 = 8'h00; end
      if (i == 2) iv8 = 1'b0;
      check("bp_out_valid_hold", ov8, 1);
      check("bp_sum_hold", sum8, 10'h186);
      @(posedge clk); #1;
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check("bp_in_ready_after", ir8, 1);
    check("bp_out_valid_after", ov8, 0);
    check("bp_sum_kept_idle", sum8, 10'h186);
    acc8(8'h02, 8'h03, lat);
    check("after_stall_sum", sum8, 10'h008);
    rel8("after_stall_in_ready");

    // asynchronous reset from the result-holding state, between edges
    acc8(8'hFF, 8'hFF, lat);
    #2 rst8 = 1'b1;
    #1;
    check("async_rst_in_ready", ir8, 1);
    check("async_rst_out_valid", ov8, 0);
    check("async_rst_busy", bz8, 0);
    check("async_rst_sum", sum8, 0);
    @(posedge clk); #1;
    rst8 = 1'b0;

    // reset during resolution discards the in-flight pair
    s32 = 32'hFFFF_FFFF; c32 = 32'h1; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst32 = 1'b1;
    #1;
    check("midop_rst_busy", bz32, 0);
    check("midop_rst_in_ready", ir32, 1);
    @(posedge clk); #1;
    rst32 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= ov32;
      @(posedge clk); #1;
    end
    check("midop_no_out_valid", seen, 0);
    acc32(32'd5, 32'd3, lat);
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
    check("midop_next_latency", lat, 1);
`else
    check("midop_next_latency", lat, 5);
`endif
    check("midop_next_sum", sum32, 34'd11);
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;

    all_done = 1'b0;
    for (int cyc = 0; cyc < 80000 && !all_done; cyc++) begin
      @(posedge clk);
      all_done = lane_done[0] && lane_done[1] && lane_done[2] && lane_done[3];
    end
    check("lanes_finished", all_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
